// File: rtl/mips_alu_muldiv.sv
// MIPS execute unit: single-cycle ALU plus iterative MULT/MULTU/DIV/DIVU into HI/LO.
// Define MIPS_ALU_DIV_EN to build the divider; otherwise ops 13/14 decode as illegal.
module mips_alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             div0,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam logic [4:0] OP_AND = 5'd0,  OP_OR   = 5'd1,  OP_ADD  = 5'd2,  OP_XOR  = 5'd3;
    localparam logic [4:0] OP_NOR = 5'd4,  OP_SLTU = 5'd5,  OP_SUB  = 5'd6,  OP_SLT  = 5'd7;
    localparam logic [4:0] OP_SLL = 5'd8,  OP_SRL  = 5'd9,  OP_SRA  = 5'd10, OP_MULT = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12, OP_DIV = 5'd13, OP_DIVU = 5'd14, OP_MFHI = 5'd15;
    localparam logic [4:0] OP_MFLO = 5'd16, OP_MTHI = 5'd17, OP_MTLO = 5'd18;

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     m_q, m_d, a_q, a_d;
    logic                 neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic                 is_div_q, is_div_d, dz_q, dz_d;
    logic [WIDTH-1:0]     result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic                 zero_q, zero_d, ovf_q, ovf_d, div0_q, div0_d;
    logic                 illegal_q, illegal_d, out_valid_q, out_valid_d;

    logic [WIDTH-1:0]     sum, diff, res, q_v, r_v;
    logic [WIDTH:0]       step;
    logic [2*WIDTH-1:0]   prod;
    logic                 single, ill;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        m_d         = m_q;
        a_d         = a_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        is_div_d    = is_div_q;
        dz_d        = dz_q;
        result_d    = result_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        zero_d      = 1'b0;
        ovf_d       = 1'b0;
        div0_d      = 1'b0;
        illegal_d   = 1'b0;
        out_valid_d = 1'b0;
        res         = '0;
        single      = 1'b1;
        ill         = 1'b0;
        step        = '0;
        prod        = '0;
        q_v         = '0;
        r_v         = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (op)
                        OP_AND:  res = a & b;
                        OP_OR:   res = a | b;
                        OP_XOR:  res = a ^ b;
                        OP_NOR:  res = ~(a | b);
                        OP_ADD: begin
                            res   = sum;
                            ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            res   = diff;
                            ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
                        OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                        OP_SLL:  res = b << shamt;
                        OP_SRL:  res = b >> shamt;
                        OP_SRA:  res = $signed(b) >>> shamt;
                        OP_MFHI: res = hi_q;
                        OP_MFLO: res = lo_q;
                        OP_MTHI: begin res = a; hi_d = a; end
                        OP_MTLO: begin res = a; lo_d = a; end
                        OP_MULT, OP_MULTU: begin
                            single   = 1'b0;
                            state_d  = S_MUL;
                            cnt_d    = SHW'(WIDTH-1);
                            m_d      = (op == OP_MULT) ? mag(a) : a;
                            p_d      = {{WIDTH{1'b0}}, ((op == OP_MULT) ? mag(b) : b)};
                            neg_lo_d = (op == OP_MULT) && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_hi_d = 1'b0;
                            is_div_d = 1'b0;
                            dz_d     = 1'b0;
                        end
`ifdef MIPS_ALU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            single   = 1'b0;
                            is_div_d = 1'b1;
                            a_d      = a;
                            dz_d     = (b == '0);
                            state_d  = (b == '0) ? S_FIX : S_DIV;
                            cnt_d    = SHW'(WIDTH-1);
                            m_d      = (op == OP_DIV) ? mag(b) : b;
                            p_d      = {{WIDTH{1'b0}}, ((op == OP_DIV) ? mag(a) : a)};
                            neg_lo_d = (op == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_hi_d = (op == OP_DIV) && a[WIDTH-1];
                        end
`endif
                        default: ill = 1'b1;
                    endcase
                    if (single) begin
                        result_d    = res;
                        zero_d      = (res == '0);
                        illegal_d   = ill;
                        out_valid_d = 1'b1;
                    end else begin
                        ovf_d = 1'b0;
                    end
                end
            end
            // Shift-add multiply: add multiplicand into the upper half, then shift right.
            S_MUL: begin
                step  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
                p_d   = {step, p_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
`ifdef MIPS_ALU_DIV_EN
            // Restoring divide: remainder in the upper half, quotient shifts into the lower.
            S_DIV: begin
                step = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
                if (step >= {1'b0, m_q}) begin
                    step = step - {1'b0, m_q};
                    p_d  = {step[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_d  = {step[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
`endif
            S_FIX: begin
                if (is_div_q) begin
                    q_v = neg_lo_q ? (~p_q[WIDTH-1:0] + 1'b1) : p_q[WIDTH-1:0];
                    r_v = neg_hi_q ? (~p_q[2*WIDTH-1:WIDTH] + 1'b1) : p_q[2*WIDTH-1:WIDTH];
                    if (dz_q) begin
                        q_v    = '1;
                        r_v    = a_q;
                        div0_d = 1'b1;
                    end
                end else begin
                    prod = neg_lo_q ? (~p_q + 1'b1) : p_q;
                    q_v  = prod[WIDTH-1:0];
                    r_v  = prod[2*WIDTH-1:WIDTH];
                end
                lo_d        = q_v;
                hi_d        = r_v;
                result_d    = q_v;
                zero_d      = (q_v == '0);
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            m_q         <= '0;
            a_q         <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            is_div_q    <= 1'b0;
            dz_q        <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            div0_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            m_q         <= m_d;
            a_q         <= a_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            is_div_q    <= is_div_d;
            dz_q        <= dz_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            div0_q      <= div0_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign div0      = div0_q;
    assign illegal   = illegal_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule
